// File: rtl/mc_ctrl_seq_if.sv
// Control bundle between the multi-cycle sequencer and the rest of the RV32I core.
// The sequencer owns the memory request side (master); datapath and memory see the slave view.
interface mc_ctrl_seq_if;
    logic [6:0]  i_opcode;
    logic        i_branch_taken;
    logic        i_mem_ready;
    logic        o_mem_req;
    logic        o_mem_we;
    logic        o_mem_addr_sel;
    logic        o_ir_we;
    logic        o_pc_we;
    logic [1:0]  o_pc_src;
    logic        o_regwrite;
    logic [1:0]  o_wb_sel;
    logic        o_retire;
    logic        o_illegal;
    logic        o_trap;
    logic [2:0]  o_state;
    logic [31:0] o_instret;

    modport master (
        input  i_opcode, i_branch_taken, i_mem_ready,
        output o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_pc_we, o_pc_src,
               o_regwrite, o_wb_sel, o_retire, o_illegal, o_trap, o_state, o_instret
    );

    modport slave (
        output i_opcode, i_branch_taken, i_mem_ready,
        input  o_mem_req, o_mem_we, o_mem_addr_sel, o_ir_we, o_pc_we, o_pc_src,
               o_regwrite, o_wb_sel, o_retire, o_illegal, o_trap, o_state, o_instret
    );
endinterface

// File: rtl/mc_ctrl_seq.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core with retired-instruction counter.
// Optional memory watchdog (timeout to TRAP) is compiled in with MC_CTRL_TIMEOUT_EN.
module mc_ctrl_seq #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    mc_ctrl_seq_if.master io_bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
    } class_e;

    state_e      r_state;
    class_e      r_class;
    logic [31:0] r_instret;

    class_e      w_class;
    logic        w_known;
    logic        w_ready;
    logic        w_mem_req, w_mem_we, w_addr_sel, w_ir_we, w_pc_we;
    logic [1:0]  w_pc_src, w_wb_sel;
    logic        w_regwrite, w_retire, w_illegal, w_trap;

    assign w_ready = io_bus.i_mem_ready;

    always_comb begin
        w_known = 1'b1;
        w_class = C_I;
        case (io_bus.i_opcode)
            7'h33:   w_class = C_R;
            7'h13:   w_class = C_I;
            7'h03:   w_class = C_LOAD;
            7'h23:   w_class = C_STORE;
            7'h63:   w_class = C_BRANCH;
            7'h6F:   w_class = C_JAL;
            7'h67:   w_class = C_JALR;
            7'h37:   w_class = C_LUI;
            7'h17:   w_class = C_AUIPC;
            default: w_known = 1'b0;
        endcase
    end

    // Moore decode of the state register; only IR load and the store completion follow ready.
    always_comb begin
        w_mem_req  = 1'b0;
        w_mem_we   = 1'b0;
        w_addr_sel = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_src   = 2'd0;
        w_regwrite = 1'b0;
        w_wb_sel   = 2'd0;
        w_retire   = 1'b0;
        w_illegal  = 1'b0;
        w_trap     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                w_ir_we   = w_ready;
            end
            S_DECODE: w_illegal = ~w_known;
            S_EXEC: begin
                if (r_class == C_BRANCH) begin
                    w_pc_we  = 1'b1;
                    w_pc_src = {1'b0, io_bus.i_branch_taken};
                    w_retire = 1'b1;
                end
            end
            S_MEM: begin
                w_mem_req  = 1'b1;
                w_addr_sel = 1'b1;
                w_mem_we   = (r_class == C_STORE);
                if ((r_class == C_STORE) && w_ready) begin
                    w_pc_we  = 1'b1;
                    w_retire = 1'b1;
                end
            end
            S_WB: begin
                w_regwrite = 1'b1;
                w_pc_we    = 1'b1;
                w_retire   = 1'b1;
                if (r_class == C_LOAD)
                    w_wb_sel = 2'd1;
                else if ((r_class == C_JAL) || (r_class == C_JALR))
                    w_wb_sel = 2'd2;
                if (r_class == C_JAL)
                    w_pc_src = 2'd1;
                else if (r_class == C_JALR)
                    w_pc_src = 2'd2;
            end
            S_TRAP:  w_trap = 1'b1;
            default: ;
        endcase
    end

`ifdef MC_CTRL_TIMEOUT_EN
    logic [7:0] r_wd;
    logic       w_timeout;
    // Trap once this waiting cycle would bring the count to MEM_TIMEOUT; ready in that cycle wins.
    assign w_timeout = w_mem_req && !w_ready && (r_wd == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_wd <= 8'd0;
        else if (w_mem_req && !w_ready)
            r_wd <= r_wd + 8'd1;
        else
            r_wd <= 8'd0;
    end
`else
    logic w_timeout;
    localparam int unused_timeout = MEM_TIMEOUT;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_FETCH;
            r_class   <= C_I;
            r_instret <= 32'd0;
        end else begin
            if (w_retire)
                r_instret <= r_instret + 32'd1;
            case (r_state)
                S_FETCH: begin
                    if (w_ready)
                        r_state <= S_DECODE;
                    else if (w_timeout)
                        r_state <= S_TRAP;
                end
                S_DECODE: begin
                    if (w_known) begin
                        r_class <= w_class;
                        r_state <= S_EXEC;
                    end else begin
                        r_state <= S_TRAP;
                    end
                end
                S_EXEC: begin
                    case (r_class)
                        C_BRANCH:       r_state <= S_FETCH;
                        C_LOAD, C_STORE: r_state <= S_MEM;
                        default:        r_state <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (w_ready)
                        r_state <= (r_class == C_STORE) ? S_FETCH : S_WB;
                    else if (w_timeout)
                        r_state <= S_TRAP;
                end
                S_WB:    r_state <= S_FETCH;
                S_TRAP:  r_state <= S_TRAP;
                default: r_state <= S_TRAP;
            endcase
        end
    end

    // Every output is forced low while reset is asserted so an abandoned instruction has no side effects.
    assign io_bus.o_mem_req      = w_mem_req  & ~i_rst;
    assign io_bus.o_mem_we       = w_mem_we   & ~i_rst;
    assign io_bus.o_mem_addr_sel = w_addr_sel & ~i_rst;
    assign io_bus.o_ir_we        = w_ir_we    & ~i_rst;
    assign io_bus.o_pc_we        = w_pc_we    & ~i_rst;
    assign io_bus.o_pc_src       = i_rst ? 2'd0 : w_pc_src;
    assign io_bus.o_regwrite     = w_regwrite & ~i_rst;
    assign io_bus.o_wb_sel       = i_rst ? 2'd0 : w_wb_sel;
    assign io_bus.o_retire       = w_retire   & ~i_rst;
    assign io_bus.o_illegal      = w_illegal  & ~i_rst;
    assign io_bus.o_trap         = w_trap     & ~i_rst;
    assign io_bus.o_state        = i_rst ? 3'd0 : r_state;
    assign io_bus.o_instret      = i_rst ? 32'd0 : r_instret;
endmodule

// File: tb/tb_mc_ctrl_seq.sv
// Randomized bench for mc_ctrl_seq: a per-instruction trace model built from the sequencing rules
// predicts every output each cycle. Define MC_CTRL_TIMEOUT_EN to check the watchdog build.
module tb_mc_ctrl_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mc_ctrl_seq_if bus();

    mc_ctrl_seq #(.MEM_TIMEOUT(4)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rdy;
        logic [15:0] vec;
        logic [31:0] instret;
    } cyc_t;

    cyc_t        q[$];
    logic [31:0] m_instret;

    logic [15:0] got_vec;
    assign got_vec = {bus.o_state, bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr_sel, bus.o_ir_we,
                      bus.o_pc_we, bus.o_pc_src, bus.o_regwrite, bus.o_wb_sel, bus.o_retire,
                      bus.o_illegal, bus.o_trap};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic rdy, input logic [2:0] st, input logic req, we, asel, irwe, pcwe,
                        input logic [1:0] src, input logic rw, input logic [1:0] wb,
                        input logic ret, ill, trp);
        cyc_t c;
        c.rdy     = rdy;
        c.vec     = {st, req, we, asel, irwe, pcwe, src, rw, wb, ret, ill, trp};
        c.instret = m_instret;
        q.push_back(c);
        if (ret)
            m_instret = m_instret + 32'd1;
    endtask

    // Expected cycle trace of one instruction: fw/mw are wait cycles before ready in FETCH/MEM.
    task automatic add_instr(input logic [6:0] op, input logic taken, input int fw, input int mw);
        logic is_st;
        logic [1:0] wb;
        logic [1:0] src;
        for (int k = 0; k < fw; k++)
            push(1'b0, 3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        push(1'b1, 3'd0, 1, 0, 0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17})) begin
            push(rnd_bit(), 3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 1, 0);
            return;
        end
        push(rnd_bit(), 3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        if (op == 7'h63) begin
            push(rnd_bit(), 3'd2, 0, 0, 0, 0, 1, {1'b0, taken}, 0, 2'd0, 1, 0, 0);
        end else if (op == 7'h03 || op == 7'h23) begin
            is_st = (op == 7'h23);
            push(rnd_bit(), 3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
            for (int k = 0; k < mw; k++)
                push(1'b0, 3'd3, 1, is_st, 1, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
            push(1'b1, 3'd3, 1, is_st, 1, 0, is_st, 2'd0, 0, 2'd0, is_st, 0, 0);
            if (!is_st)
                push(rnd_bit(), 3'd4, 0, 0, 0, 0, 1, 2'd0, 1, 2'd1, 1, 0, 0);
        end else begin
            wb  = (op == 7'h6F || op == 7'h67) ? 2'd2 : 2'd0;
            src = (op == 7'h6F) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
            push(rnd_bit(), 3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
            push(rnd_bit(), 3'd4, 0, 0, 0, 0, 1, src, 1, wb, 1, 0, 0);
        end
    endtask

    task automatic add_trap(input int n);
        for (int k = 0; k < n; k++)
            push(rnd_bit(), 3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 1);
    endtask

    task automatic run_q(input string tag);
        int n;
        n = q.size();
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            @(posedge clk);
            #1;
            rst             = 1'b0;
            bus.i_mem_ready = c.rdy;
            @(negedge clk);
            check({tag, "_outs"}, {16'd0, got_vec}, {16'd0, c.vec});
            check({tag, "_instret"}, bus.o_instret, c.instret);
        end
        $display("txn %s op=%h taken=%0d cycles=%0d instret=%0d", tag, bus.i_opcode,
                 bus.i_branch_taken, n, bus.o_instret);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            rst             = 1'b1;
            bus.i_mem_ready = 1'b1;
            @(negedge clk);
            check("rst_outs", {16'd0, got_vec}, 32'd0);
            check("rst_instret", bus.o_instret, 32'd0);
        end
        m_instret = 32'd0;
        $display("txn reset cycles=%0d", n);
    endtask

    task automatic one(input string tag, input logic [6:0] op, input logic taken, input int fw, input int mw);
        bus.i_opcode       = op;
        bus.i_branch_taken = taken;
        add_instr(op, taken, fw, mw);
        run_q(tag);
    endtask

    logic [6:0] legal_ops [9];

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        m_instret          = 32'd0;
        rst                = 1'b1;
        bus.i_opcode       = 7'h13;
        bus.i_branch_taken = 1'b0;
        bus.i_mem_ready    = 1'b1;
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

        do_reset(2);

        one("addi", 7'h13, 1'b0, 0, 0);
        one("load_w3", 7'h03, 1'b0, 0, 3);
        one("br_taken", 7'h63, 1'b1, 0, 0);
        one("br_not", 7'h63, 1'b0, 0, 0);
        one("store", 7'h23, 1'b0, 0, 0);
        one("jal", 7'h6F, 1'b0, 1, 0);
        one("jalr", 7'h67, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            logic [6:0] op;
            op = legal_ops[$urandom_range(0, 8)];
            one("rand", op, rnd_bit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset lands in the MEM ready cycle of a store.
        do_reset(1);
        bus.i_opcode = 7'h23;
        add_instr(7'h23, 1'b0, 0, 5);
        while (q.size() > 5)
            void'(q.pop_back());
        run_q("st_pre_rst");
        do_reset(1);
        push(1'b0, 3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        run_q("st_post_rst");

        // Illegal opcode parks the core in TRAP with no further requests.
        do_reset(1);
        bus.i_opcode = 7'h7F;
        add_instr(7'h7F, 1'b0, 1, 0);
        add_trap(12);
        run_q("illegal");
        do_reset(1);
        one("after_trap", 7'h33, 1'b0, 0, 0);

`ifdef MC_CTRL_TIMEOUT_EN
        for (int k = 0; k < 4; k++)
            push(1'b0, 3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        add_trap(10);
        run_q("watchdog");
`else
        for (int k = 0; k < 100; k++)
            push(1'b0, 3'd0, 1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        run_q("no_watchdog");
`endif
        do_reset(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
